fw_wishbone_sram_ctrl_single: RTL and testbench

FW_WISHBONE_SRAM_CTRL_SINGLE -- requirements
Module: fw_wishbone_sram_ctrl_single

---
 rtl/fw_wishbone_sram_ctrl_single.sv | 96 +++++++++
 tb/tb_fw_wishbone_sram_ctrl_single.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fw_wishbone_sram_ctrl_single.sv
// -----------------------------------------------------------------------------
// fw_wishbone_sram_ctrl_single
//
// Wishbone slave bridging single transfers onto a synchronous SRAM with
// one cycle of read latency. The bridge accepts one request, presents the
// address (and the write strobe for writes) to the SRAM in that cycle, then
// acknowledges in the following cycle. At that point read data from the SRAM
// is valid.
//
// Ports
//   clock, reset      single rising-edge clock, synchronous active-high reset
//   t_adr             Wishbone byte address
//   t_dat_w/t_dat_r   Wishbone write / read data
//   t_cyc, t_stb      bus cycle and strobe
//   t_we              1 = write, 0 = read
//   t_sel             byte selects
//   t_ack             transfer acknowledge (one pulse per accepted request)
//   t_err, t_tgd_r    always 0
//   t_tga, t_tgd_w,
//   t_tgc             tags, ignored
//   i_addr            SRAM word address (byte address >> log2(bytes/word))
//   i_write_en        SRAM write strobe, one cycle per accepted write
//   i_byte_en         SRAM byte enables (= t_sel)
//   i_write_data      SRAM write data (= t_dat_w)
//   i_read_data       SRAM read data, valid one cycle after the address
// -----------------------------------------------------------------------------
module fw_wishbone_sram_ctrl_single #(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADR_WIDTH-1:0]   t_adr,
  input  logic [DAT_WIDTH-1:0]   t_dat_w,
  output logic [DAT_WIDTH-1:0]   t_dat_r,
  input  logic                   t_cyc,
  input  logic                   t_stb,
  input  logic                   t_we,
  input  logic [DAT_WIDTH/8-1:0] t_sel,
  output logic                   t_ack,
  output logic                   t_err,
  input  logic                   t_tga,
  input  logic                   t_tgd_w,
  output logic                   t_tgd_r,
  input  logic [3:0]             t_tgc,
  output logic [ADR_WIDTH-1:0]   i_addr,
  output logic                   i_write_en,
  output logic [DAT_WIDTH/8-1:0] i_byte_en,
  output logic [DAT_WIDTH-1:0]   i_write_data,
  input  logic [DAT_WIDTH-1:0]   i_read_data
);

  localparam int unsigned BYTE_SHIFT = $clog2(DAT_WIDTH / 8);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t state;
  logic   req;

  assign req = t_cyc & t_stb;

  // Only one transfer in flight: a request is accepted from IDLE only, and
  // ACK always falls back to IDLE, whether or not the master kept the strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= req ? ACK : IDLE;
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Ack and write strobe are gated by the live bus signals and by reset, so
  // a dropped strobe or a reset landing in ACK never yields a stray pulse.
  assign t_ack      = (state == ACK)  & req & ~reset;
  assign i_write_en = (state == IDLE) & req & t_we & ~reset;

  assign i_addr       = t_adr >> BYTE_SHIFT;
  assign i_write_data = t_dat_w;
  assign i_byte_en    = t_sel;
  assign t_dat_r      = i_read_data;

  assign t_err   = 1'b0;
  assign t_tgd_r = 1'b0;

  // Tags are accepted for bus compatibility but carry no meaning here.
  logic unused_tags;
  assign unused_tags = ^{t_tga, t_tgd_w, t_tgc};

endmodule

// File: tb/tb_fw_wishbone_sram_ctrl_single.sv
module tb_fw_wishbone_sram_ctrl_single;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] t_adr;
  logic [31:0] t_dat_w;
  logic [31:0] t_dat_r;
  logic        t_cyc, t_stb, t_we;
  logic [3:0]  t_sel;
  logic        t_ack, t_err;
  logic        t_tga, t_tgd_w, t_tgd_r;
  logic [3:0]  t_tgc;
  logic [31:0] i_addr;
  logic        i_write_en;
  logic [3:0]  i_byte_en;
  logic [31:0] i_write_data;
  logic [31:0] i_read_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  fw_wishbone_sram_ctrl_single #(
    .ADR_WIDTH(32),
    .DAT_WIDTH(32)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .t_adr        (t_adr),
    .t_dat_w      (t_dat_w),
    .t_dat_r      (t_dat_r),
    .t_cyc        (t_cyc),
    .t_stb        (t_stb),
    .t_we         (t_we),
    .t_sel        (t_sel),
    .t_ack        (t_ack),
    .t_err        (t_err),
    .t_tga        (t_tga),
    .t_tgd_w      (t_tgd_w),
    .t_tgd_r      (t_tgd_r),
    .t_tgc        (t_tgc),
    .i_addr       (i_addr),
    .i_write_en   (i_write_en),
    .i_byte_en    (i_byte_en),
    .i_write_data (i_write_data),
    .i_read_data  (i_read_data)
  );

  // Synchronous SRAM model: 64 words, byte-enabled write, registered read.
  logic [31:0] mem [64];
  always @(posedge clock) begin
    if (i_write_en) begin
      for (int b = 0; b < 4; b++)
        if (i_byte_en[b]) mem[i_addr[5:0]][8*b +: 8] <= i_write_data[8*b +: 8];
    end
    i_read_data <= mem[i_addr[5:0]];
  end

  task automatic bus_idle();
    t_cyc = 1'b0; t_stb = 1'b0; t_we = 1'b0;
  endtask

  // Drives one request and watches until ack (bounded to 8 cycles).
  // Leaves the request driven; the caller decides when to drop it.
  task automatic bus_xfer(input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel,
                          output logic [31:0] rd, output int ncyc,
                          output int acks, output int wens,
                          output logic [31:0] wen_addr, output int tagbad);
    t_cyc = 1'b1; t_stb = 1'b1; t_we = we;
    t_adr = adr; t_dat_w = dat; t_sel = sel;
    t_tga = 1'b1; t_tgd_w = 1'b1; t_tgc = 4'hA;
    rd = 'x; ncyc = 0; acks = 0; wens = 0; wen_addr = 'x; tagbad = 0;
    while (acks == 0 && ncyc < 8) begin
      @(negedge clock);
      ncyc++;
      if (i_write_en) begin wens++; wen_addr = i_addr; end
      if (t_ack) begin
        acks++;
        rd = t_dat_r;
        if (t_err !== 1'b0 || t_tgd_r !== 1'b0) tagbad++;
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_idle();
    t_adr = '0; t_dat_w = '0; t_sel = '0;
    t_tga = 1'b0; t_tgd_w = 1'b0; t_tgc = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    vectors++;
    if ({t_ack, i_write_en, t_err, t_tgd_r} !== 4'b0000) begin
      $display("FAIL reset_outputs: ack/wen/err/tgd = %b, expected 0000",
               {t_ack, i_write_en, t_err, t_tgd_r});
      miscompares++;
    end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_full_write_read();
    logic [31:0] rd, wa; int n, a, w, tb;
    bus_xfer(1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, rd, n, a, w, wa, tb);
    bus_idle();
    vectors++;
    if (w !== 1 || wa !== 32'h4) begin
      $display("FAIL write_pulse: wen count %0d addr %h, expected 1 at 00000004", w, wa);
      miscompares++;
    end
    vectors++;
    if (n !== 2 || a !== 1) begin
      $display("FAIL write_ack_latency: cycles %0d acks %0d, expected 2 and 1", n, a);
      miscompares++;
    end
    bus_xfer(1'b0, 32'h0000_0010, 32'h0, 4'hF, rd, n, a, w, wa, tb);
    bus_idle();
    vectors++;
    if (rd !== 32'hDEADBEEF || n !== 2) begin
      $display("FAIL read_back: data %h cycles %0d, expected deadbeef and 2", rd, n);
      miscompares++;
    end
  endtask

  task automatic test_partial_write();
    logic [31:0] rd, wa; int n, a, w, tb;
    bus_xfer(1'b1, 32'h20, 32'h11223344, 4'hF, rd, n, a, w, wa, tb);
    bus_xfer(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, n, a, w, wa, tb);
    bus_xfer(1'b0, 32'h20, 32'h0, 4'hF, rd, n, a, w, wa, tb);
    bus_idle();
    vectors++;
    if (rd !== 32'h11BB33DD) begin
      $display("FAIL partial_write: read %h, expected 11bb33dd", rd);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, wa; int n, a, w, tb;
    int bad_timing = 0, bad_data = 0;
    for (int i = 0; i < 16; i++) begin
      bus_xfer(1'b1, 32'(4 * i), 32'(i), 4'hF, rd, n, a, w, wa, tb);
      if (n != 2 || a != 1 || w != 1) bad_timing++;
    end
    for (int i = 0; i < 16; i++) begin
      bus_xfer(1'b0, 32'(4 * i), 32'h0, 4'hF, rd, n, a, w, wa, tb);
      if (n != 2 || a != 1 || w != 0) bad_timing++;
      if (rd !== 32'(i)) bad_data++;
    end
    bus_idle();
    vectors++;
    if (bad_timing !== 0) begin
      $display("FAIL b2b_timing: %0d transfers off, expected 0", bad_timing);
      miscompares++;
    end
    vectors++;
    if (bad_data !== 0) begin
      $display("FAIL b2b_data: %0d reads wrong, expected 0", bad_data);
      miscompares++;
    end
  endtask

  task automatic test_read_no_we();
    logic [31:0] rd, wa; int n, a, w, tb;
    int wsum = 0, tsum = 0;
    for (int i = 0; i < 4; i++) begin
      bus_xfer(1'b0, 32'(8 * i), 32'hFFFF_FFFF, 4'hF, rd, n, a, w, wa, tb);
      wsum += w; tsum += tb;
    end
    bus_idle();
    vectors++;
    if (wsum !== 0) begin
      $display("FAIL read_no_wen: wen pulses %0d, expected 0", wsum);
      miscompares++;
    end
    vectors++;
    if (tsum !== 0) begin
      $display("FAIL ack_err_tgd: %0d acks with err/tgd set, expected 0", tsum);
      miscompares++;
    end
    bus_xfer(1'b0, 32'h4, 32'h0, 4'hF, rd, n, a, w, wa, tb);
    bus_idle();
    vectors++;
    if (rd !== 32'h1) begin
      $display("FAIL read_unaltered: read %h, expected 00000001", rd);
      miscompares++;
    end
  endtask

  task automatic test_reset_storm();
    int bad = 0;
    // Accept a read, then hit reset while in ACK.
    t_cyc = 1'b1; t_stb = 1'b1; t_we = 1'b0; t_adr = 32'h8;
    @(posedge clock); #1;
    reset = 1'b1; t_we = 1'b1;
    @(negedge clock);
    vectors++;
    if (t_ack !== 1'b0) begin
      $display("FAIL reset_in_ack: ack %b, expected 0", t_ack);
      miscompares++;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (t_ack !== 1'b0 || i_write_en !== 1'b0 || t_err !== 1'b0 || t_tgd_r !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      $display("FAIL reset_hold: %0d cycles with activity, expected 0", bad);
      miscompares++;
    end
    t_adr = 32'h3C; t_dat_w = 32'h5A5A_0F0F; t_sel = 4'hF;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if ({t_ack, i_write_en} !== 2'b01) begin
      $display("FAIL post_reset_cycle1: ack/wen %b, expected 01", {t_ack, i_write_en});
      miscompares++;
    end
    @(negedge clock);
    vectors++;
    if ({t_ack, i_write_en} !== 2'b10) begin
      $display("FAIL post_reset_cycle2: ack/wen %b, expected 10", {t_ack, i_write_en});
      miscompares++;
    end
    @(posedge clock); #1;
    bus_idle();
    @(posedge clock); #1;
  endtask

  task automatic test_stb_drop();
    logic [31:0] rd, wa; int n, a, w, tb;
    int ack_seen = 0;
    t_cyc = 1'b1; t_stb = 1'b1; t_we = 1'b1;
    t_adr = 32'h30; t_dat_w = 32'hCAFE_F00D; t_sel = 4'hF;
    @(negedge clock);
    vectors++;
    if (i_write_en !== 1'b1) begin
      $display("FAIL drop_accept: wen %b, expected 1", i_write_en);
      miscompares++;
    end
    @(posedge clock); #1;
    t_stb = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (t_ack) ack_seen++;
      @(posedge clock); #1;
    end
    vectors++;
    if (ack_seen !== 0) begin
      $display("FAIL drop_no_ack: %0d acks, expected 0", ack_seen);
      miscompares++;
    end
    bus_xfer(1'b0, 32'h30, 32'h0, 4'hF, rd, n, a, w, wa, tb);
    bus_idle();
    vectors++;
    if (rd !== 32'hCAFEF00D || n !== 2 || a !== 1) begin
      $display("FAIL drop_followup: data %h cycles %0d acks %0d, expected cafef00d 2 1",
               rd, n, a);
      miscompares++;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    test_reset();
    test_full_write_read();
    test_partial_write();
    test_back_to_back();
    test_read_no_we();
    test_reset_storm();
    test_stb_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
